// File: rtl/divmod_seq_arbiter_if.sv
// Request/response bundle for divmod_seq_arbiter: two divide requesters and one tagged result channel.
interface divmod_seq_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             resp_valid;
   logic             resp_ready;
   logic             resp_id;
   logic [WIDTH-1:0] resp_q;
   logic [WIDTH-1:0] resp_r;
   logic             resp_dbz;

   modport master (
      output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, resp_ready,
      input  req0_ready, req1_ready, resp_valid, resp_id, resp_q, resp_r, resp_dbz
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, resp_ready,
      output req0_ready, req1_ready, resp_valid, resp_id, resp_q, resp_r, resp_dbz
   );
endinterface

// File: rtl/divmod_seq_arbiter.sv
// Shared restoring divider (one quotient bit per clock) with round-robin arbitration between two requesters.
// Optional DIVMOD_FASTPATH_EN: jobs with a<b (b!=0) complete without iterating.
module divmod_seq_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   divmod_seq_arbiter_if.slave  bus,
   output logic                 busy
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state, state_nx;
   logic             last_grant;
   logic             id;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH:0]   rem;
   logic             resp_id;
   logic [WIDTH-1:0] resp_q;
   logic [WIDTH-1:0] resp_r;
   logic             resp_dbz;

   logic             gnt_id;
   logic             accept;
   logic             rdy0, rdy1;
   logic             last_iter;
   logic [WIDTH-1:0] sel_a, sel_b;

   // Shift one extra bit so the subtraction's borrow doubles as the compare.
   logic [WIDTH+1:0] rem_sh, diff;
   logic             ge;
   logic [WIDTH:0]   rem_nx;
   logic [WIDTH-1:0] dvd_nx;

   assign gnt_id    = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
   assign sel_a     = gnt_id ? bus.req1_a : bus.req0_a;
   assign sel_b     = gnt_id ? bus.req1_b : bus.req0_b;
   assign last_iter = (cnt == CW'(WIDTH-1));

   assign rem_sh = {rem, dvd[WIDTH-1]};
   assign diff   = rem_sh - {2'b00, dvs};
   assign ge     = ~diff[WIDTH+1];
   assign rem_nx = ge ? diff[WIDTH:0] : rem_sh[WIDTH:0];
   assign dvd_nx = {dvd[WIDTH-2:0], ge};

   always_comb begin
      state_nx = state;
      rdy0     = 1'b0;
      rdy1     = 1'b0;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req0_valid || bus.req1_valid) begin
               accept = 1'b1;
               rdy0   = ~gnt_id;
               rdy1   = gnt_id;
`ifdef DIVMOD_FASTPATH_EN
               if (sel_b == '0 || sel_a < sel_b) state_nx = DONE;
               else                              state_nx = CALC;
`else
               if (sel_b == '0) state_nx = DONE;
               else             state_nx = CALC;
`endif
            end
         end
         CALC: if (last_iter) state_nx = DONE;
         DONE: if (bus.resp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         id         <= 1'b0;
         cnt        <= '0;
         dvd        <= '0;
         dvs        <= '0;
         rem        <= '0;
         resp_id    <= 1'b0;
         resp_q     <= '0;
         resp_r     <= '0;
         resp_dbz   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  last_grant <= gnt_id;
                  id         <= gnt_id;
                  dvd        <= sel_a;
                  dvs        <= sel_b;
                  rem        <= '0;
                  cnt        <= '0;
                  // Short-circuit jobs load the result now; DONE follows on the next edge.
                  if (sel_b == '0) begin
                     resp_id  <= gnt_id;
                     resp_q   <= '1;
                     resp_r   <= sel_a;
                     resp_dbz <= 1'b1;
                  end
`ifdef DIVMOD_FASTPATH_EN
                  else if (sel_a < sel_b) begin
                     resp_id  <= gnt_id;
                     resp_q   <= '0;
                     resp_r   <= sel_a;
                     resp_dbz <= 1'b0;
                  end
`endif
               end
            end
            CALC: begin
               dvd <= dvd_nx;
               rem <= rem_nx;
               cnt <= cnt + 1'b1;
               if (last_iter) begin
                  resp_id  <= id;
                  resp_q   <= dvd_nx;
                  resp_r   <= rem_nx[WIDTH-1:0];
                  resp_dbz <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req0_ready = rdy0;
   assign bus.req1_ready = rdy1;
   assign bus.resp_valid = (state == DONE);
   assign bus.resp_id    = resp_id;
   assign bus.resp_q     = resp_q;
   assign bus.resp_r     = resp_r;
   assign bus.resp_dbz   = resp_dbz;
   assign busy           = (state != IDLE);
endmodule

// File: doc/divmod_seq_arbiter.md
Name: divmod_seq_arbiter

Overview:
- Sequential 32-bit unsigned quotient/remainder engine (restoring, one quotient bit per clock) shared between two requesters.
- Round-robin arbitration feeds the single iterative datapath; results return on one response channel tagged with the requester ID.
- Replaces replicated combinational division/modulus logic wherever throughput allows multi-cycle latency.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits; iteration count per job.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle when valid&&ready
- req0_a  in  WIDTH  requester 0 dividend
- req0_b  in  WIDTH  requester 0 divisor
- req1_valid / req1_ready / req1_a / req1_b  same as requester 0, for requester 1
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result when valid&&ready
- resp_id  out  1  requester that issued the result
- resp_q  out  WIDTH  quotient a/b
- resp_r  out  WIDTH  remainder a%b
- resp_dbz  out  1  divide-by-zero flag
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE; resp_valid, resp_id, resp_q, resp_r, resp_dbz, busy all 0; last_grant=1, so requester 0 wins the first contest.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - reqN_ready is combinational and asserted only for the granted requester.
  - Grant: the sole valid requester; if both are valid, the one not equal to last_grant.
  - On the accept edge: latch a, b, id; update last_grant; clear the iteration counter.
  - Next state: CALC, or DONE if b==0.
- CALC:
  - Remainder register is WIDTH+1 bits.
  - Each edge: rem = {rem, dividend MSB}; dividend shifts left. If rem>=b: rem-=b and shift in quotient bit 1, else shift in 0.
  - After exactly WIDTH iterations, go to DONE.
- DONE:
  - resp_valid=1. resp_q, resp_r, resp_id, resp_dbz are registered and stable while resp_valid && !resp_ready.
  - On resp_valid&&resp_ready: go to IDLE and drop resp_valid.
- Latency (accept edge E0):
  - Normal: resp_valid high in the cycle after edge E0+WIDTH (after E32 for WIDTH=32).
  - b==0: resp_valid high in the cycle after E0.
- Throughput: no new accept in the cycle a response is consumed; minimum one IDLE cycle between jobs.
- Divide by zero: resp_q = all ones, resp_r = a, resp_dbz = 1. Otherwise resp_dbz = 0.
- Both ready signals are low outside IDLE. Requests held during CALC/DONE wait; unaccepted valids are not dropped.
- Arbitration is fair: with both requesters continuously valid, grants alternate 0,1,0,1.
- Reset mid-operation (CALC or DONE): the in-flight job is discarded, no response is issued, and the reset values above are restored on the next edge.
- a < b is not special-cased without the optional feature: the full WIDTH iterations run, giving q=0, r=a.

Optional Feature:
- Macro: DIVMOD_FASTPATH_EN
- Defined: on the accept edge, if b!=0 and a<b, skip CALC and go directly to DONE with q=0, r=a, dbz=0. resp_valid is high in the cycle after E0.
- Undefined: every job with b!=0 takes WIDTH CALC cycles.

Test Plan:
- req0 a=100, b=7, resp_ready=1 -> resp_q=14, resp_r=2, resp_id=0, dbz=0; resp_valid first high 32 edges after accept.
- req1 a=1234102, b=10 -> resp_q=123410, resp_r=2, resp_id=1.
- req0 a=5, b=0 -> resp_q=32'hFFFFFFFF, resp_r=5, dbz=1; resp_valid in the cycle after accept.
- Both valid from reset, (a=9,b=2) on req0 and (a=20,b=6) on req1, held valid -> req0 served first (q=4, r=1, id=0), then req1 (q=3, r=2, id=1); reqN_ready never high outside IDLE.
- resp_ready low for 5 cycles in DONE -> resp_* held constant, both reqN_ready=0; on the 6th cycle resp_ready=1 -> consumed, next cycle IDLE.
- Reset asserted on the 10th CALC cycle -> resp_valid stays 0, busy=0; a new req0 of a=15, b=4 afterwards gives q=3, r=3 with resp_id=0.
- With DIVMOD_FASTPATH_EN: a=3, b=10 -> q=0, r=3 in the cycle after accept. Without it: same result after 32 edges.
